// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// The optional memory-mapped output register is enabled by defining DMEM_MMIO_EN.
package dmem_pkg;

   // Controller sequence: accept, optional wait states, RAM access, one-cycle
   // response, then hold until the core drops its request.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_RESP    = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Width of the wait-state counter (WAIT_STATES is limited to 0..15).
   localparam int WAIT_W = 4;

   // The MMIO register sits at word address DEPTH + MMIO_OFFSET.
   localparam int MMIO_OFFSET = 0;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with read-first behaviour.
// No reset on the array or the read register so it maps onto block RAM.
module dmem_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write on we; the registered read returns the word as it was before the edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the core's load/store port.
// Accepts one request at a time, inserts WAIT_STATES idle cycles, performs the
// RAM access and pulses response for one cycle. Define DMEM_MMIO_EN to add the
// mmio_out register mapped at address DEPTH.
//
// Handshake: the core raises request with wren/address/writedata valid and holds
// request high until it sees the one-cycle response pulse. Inputs are sampled
// only in IDLE; after the response the controller waits in RELEASE until request
// is low, so a request held high never starts a second transaction.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             request,
   input  logic             wren,
   input  logic [WIDTH-1:0] address,
   input  logic [WIDTH-1:0] writedata,
   output logic             response,
   output logic [WIDTH-1:0] readdata,
   output logic             busy
`ifdef DMEM_MMIO_EN
   ,
   output logic [WIDTH-1:0] mmio_out
`endif
);

   localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
   localparam logic [WAIT_W-1:0] WS_INIT = WAIT_W'(WAIT_STATES);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   // ACCESS takes two cycles: phase 0 issues the RAM op, phase 1 captures its output.
   logic              phase_q, phase_d;
   logic              wren_q, wren_d;
   logic [WIDTH-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [WIDTH-1:0]  readdata_q, readdata_d;

   logic              in_range;
   logic              op_cycle;
   logic              ram_we;
   logic [WIDTH-1:0]  ram_rdata;
   logic [WIDTH-1:0]  load_val;

   assign in_range = (addr_q < DEPTH_W);
   assign op_cycle = (state_q == ST_ACCESS) && !phase_q;
   // Out-of-range stores are dropped here; only the low AW bits reach the RAM.
   assign ram_we   = op_cycle && wren_q && in_range;

   dmem_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

`ifdef DMEM_MMIO_EN
   localparam logic [WIDTH-1:0] MMIO_ADDR = WIDTH'(DEPTH + MMIO_OFFSET);

   logic             mmio_hit;
   logic [WIDTH-1:0] mmio_q, mmio_d;

   assign mmio_hit = (addr_q == MMIO_ADDR);

   // Store to the MMIO address updates the output register.
   always_comb begin
      mmio_d = mmio_q;
      if (op_cycle && wren_q && mmio_hit) begin
         mmio_d = wdata_q;
      end
   end

   // MMIO register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmio_q <= '0;
      end else begin
         mmio_q <= mmio_d;
      end
   end

   assign mmio_out = mmio_q;
`endif

   // Select the load result: RAM word, MMIO register, or zero when unmapped.
   always_comb begin
      load_val = '0;
      if (in_range) begin
         load_val = ram_rdata;
      end
`ifdef DMEM_MMIO_EN
      else if (mmio_hit) begin
         load_val = mmio_q;
      end
`endif
   end

   // Next-state logic: sequencing, request latching, wait counting, load capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      wren_d     = wren_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      readdata_d = readdata_q;
      case (state_q)
         ST_IDLE: begin
            if (request) begin
               wren_d  = wren;
               addr_d  = address;
               wdata_d = writedata;
               cnt_d   = WS_INIT;
               phase_d = 1'b0;
               state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_q <= WAIT_W'(1)) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               // Stores leave readdata holding the previous load result.
               if (!wren_q) begin
                  readdata_d = load_val;
               end
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!request) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         wren_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         wren_q     <= wren_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         readdata_q <= readdata_d;
      end
   end

   assign response = (state_q == ST_RESP);
   assign busy     = (state_q != ST_IDLE);
   assign readdata = readdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances, one with WAIT_STATES=2 (index 0)
// and one with WAIT_STATES=0 (index 1), driven by directed transactions.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

   localparam int W = 32;
   localparam int D = 1024;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         req  [2];
   logic         wr   [2];
   logic [W-1:0] adr  [2];
   logic [W-1:0] wdat [2];
   logic         resp [2];
   logic [W-1:0] rdat [2];
   logic         bsy  [2];
`ifdef DMEM_MMIO_EN
   logic [W-1:0] mmio [2];
`endif

   data_mem_ctrl #(.WIDTH(W), .DEPTH(D), .WAIT_STATES(2)) dut_ws2 (
      .clk(clk), .rst_n(rst_n), .request(req[0]), .wren(wr[0]),
      .address(adr[0]), .writedata(wdat[0]), .response(resp[0]),
      .readdata(rdat[0]), .busy(bsy[0])
`ifdef DMEM_MMIO_EN
      , .mmio_out(mmio[0])
`endif
   );

   data_mem_ctrl #(.WIDTH(W), .DEPTH(D), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .rst_n(rst_n), .request(req[1]), .wren(wr[1]),
      .address(adr[1]), .writedata(wdat[1]), .response(resp[1]),
      .readdata(rdat[1]), .busy(bsy[1])
`ifdef DMEM_MMIO_EN
      , .mmio_out(mmio[1])
`endif
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   bit           exp_chk_q[$];
   int           exp_dut_q[$];
   int           exp_cyc_q[$];
   int           total = 0;
   int           bad   = 0;

   logic [W-1:0] last_rd [2];
   bit           last_ok [2];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the head of the expected queue.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (resp[d] === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_response: dut %0d pulsed at cycle %0d, expected none", d, cyc);
            end else begin
               logic [W-1:0] e;
               bit           c;
               int           ed;
               int           ec;
               e  = exp_q.pop_front();
               c  = exp_chk_q.pop_front();
               ed = exp_dut_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("resp_dut", d, ed);
               check("resp_cycle", cyc, ec);
               if (c) check("readdata", rdat[d], e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic txn(input int d, input logic we, input logic [W-1:0] a,
                      input logic [W-1:0] wd, input int hold,
                      input logic [W-1:0] ld_exp, input bit ld_chk);
      int  ws;
      int  n;
      bit  seen;
      ws = (d == 0) ? 2 : 0;
      @(negedge clk);
      req[d]  = 1'b1;
      wr[d]   = we;
      adr[d]  = a;
      wdat[d] = wd;
      exp_dut_q.push_back(d);
      exp_cyc_q.push_back(cyc + ws + 3);
      if (we) begin
         exp_q.push_back(last_rd[d]);
         exp_chk_q.push_back(last_ok[d]);
      end else begin
         exp_q.push_back(ld_exp);
         exp_chk_q.push_back(ld_chk);
         last_rd[d] = ld_exp;
         last_ok[d] = ld_chk;
      end
      @(negedge clk);
      check("busy_after_sample", {31'b0, bsy[d]}, 1);
      // Core changes its inputs mid-transaction; these must be ignored.
      wr[d]   = ~we;
      adr[d]  = $urandom;
      wdat[d] = $urandom;
      seen = 0;
      n    = 0;
      while (!seen && n < 50) begin
         if (resp[d] === 1'b1) seen = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL resp_timeout: dut %0d addr %h no response within 50 cycles", d, a);
      end
      repeat (hold) @(negedge clk);
      req[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_idle", {31'b0, bsy[d]}, 0);
   endtask

   // Overall time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; wr[d] = 1'b0; adr[d] = '0; wdat[d] = '0;
         last_rd[d] = '0; last_ok[d] = 1'b1;
      end
      // 1: reset values, then idle without a response
      rst_n = 1'b0;
      #3;
      for (int d = 0; d < 2; d++) begin
         check("rst_response", {31'b0, resp[d]}, 0);
         check("rst_readdata", rdat[d], 0);
         check("rst_busy", {31'b0, bsy[d]}, 0);
`ifdef DMEM_MMIO_EN
         check("rst_mmio", mmio[d], 0);
`endif
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", {31'b0, bsy[0]}, 0);

      // 2: store 7 to addr 2 (WAIT_STATES=2)
      txn(0, 1'b1, 32'd2, 32'd7, 0, '0, 1'b0);
      // 3: load never-written addr 5 (value unchecked), load addr 2 holding request
      txn(0, 1'b0, 32'd5, 32'd0, 0, '0, 1'b0);
      txn(0, 1'b0, 32'd2, 32'd0, 10, 32'd7, 1'b1);

      // 4: WAIT_STATES=0, top word
      txn(1, 1'b1, 32'd1023, 32'hDEADBEEF, 0, '0, 1'b0);
      txn(1, 1'b0, 32'd1023, 32'd0, 0, 32'hDEADBEEF, 1'b1);

      // 5: out of range; 4096 aliases word 0 in its low bits
      txn(0, 1'b1, 32'd0, 32'h11, 0, '0, 1'b0);
      txn(0, 1'b1, 32'd4096, 32'd5, 0, '0, 1'b0);
      txn(0, 1'b0, 32'd4096, 32'd0, 0, 32'd0, 1'b1);
`ifdef DMEM_MMIO_EN
      txn(0, 1'b1, 32'd1024, 32'h55, 0, '0, 1'b0);
      check("mmio_out", mmio[0], 32'h55);
      txn(0, 1'b0, 32'd1024, 32'd0, 0, 32'h55, 1'b1);
`else
      txn(0, 1'b1, 32'd1024, 32'h55, 0, '0, 1'b0);
      txn(0, 1'b0, 32'd1024, 32'd0, 0, 32'd0, 1'b1);
`endif
      txn(0, 1'b0, 32'd0, 32'd0, 0, 32'h11, 1'b1);

      // 6: reset during WAIT of a load
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'd2;
      @(negedge clk);
      check("busy_in_wait", {31'b0, bsy[0]}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, bsy[0]}, 0);
      check("abort_response", {31'b0, resp[0]}, 0);
      check("abort_readdata", rdat[0], 0);
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = '0;
         last_ok[d] = 1'b1;
      end
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      txn(0, 1'b0, 32'd2, 32'd0, 0, 32'd7, 1'b1);

      repeat (5) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d responses still outstanding, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
